mmio_bus_arbiter: RTL and testbench
===================================

// Module: mmio_bus_arbiter
// PURPOSE
//  Shares the single FPro MMIO bus of the sampler I/O subsystem between two masters.
//  Master 0 is the CPU bridge; master 1 is an autonomous sensor-poll sequencer.
//  Each master issues one transaction at a time over a req/ack handshake.
//  Arbitration is round-robin, with an optional bounded lock for back-to-back transactions.
//  Sits between the masters and the mmio_* inputs of the I/O subsystem.
// PARAMETERS
//  HOLD_MAX  4  max consecutive locked grants to one master before forced rotation (>=1)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  m_req         in   2   per-master request; hold high until m_ack
//  m_wr          in   2   per-master write strobe (qualifies m_req)
//  m_rd          in   2   per-master read strobe (qualifies m_req)
//  m_lock        in   2   per-master request to keep the bus for its next transaction
//  m_addr        in   42  master i address = m_addr[21*i+20 : 21*i]
//  m_wr_data     in   64  master i write data = m_wr_data[32*i+31 : 32*i]
//  m_ack         out  2   one-cycle completion pulse to the granted master
//  m_err         out  2   one-cycle pulse with m_ack when the request was malformed
//  m_rd_data     out  32  read data; valid in the m_ack cycle
//  mmio_cs       out  1   bus chip select, one cycle per transaction
//  mmio_wr       out  1   bus write strobe
//  mmio_rd       out  1   bus read strobe
//  mmio_addr     out  21  bus address
//  mmio_wr_data  out  32  bus write data
//  mmio_rd_data  in   32  bus read data (combinational from the slot, same cycle)
// BEHAVIOUR
//  Reset (async): state=IDLE, last_gnt=1, lock cleared, hold_cnt=0.
//   All outputs are 0, including mmio_addr, mmio_wr_data and m_rd_data.
//  FSM: IDLE -> ISSUE -> ACK -> IDLE, one transaction per pass.
//   Latency: req seen in IDLE cycle N; bus cycle in N+1; m_ack in N+2; IDLE again in N+3.
//  IDLE grant selection:
//   - If a lock is active and the owner's m_req=1, the owner wins.
//   - Otherwise, if one request is pending, that master wins.
//   - Otherwise, if both are pending, the master != last_gnt wins.
//   - If nothing is pending, stay in IDLE.
//   - On grant, register gnt, addr, wr_data, rd, wr, and update last_gnt.
//  Lock handling, evaluated at grant:
//   - m_lock[gnt]=1 and hold_cnt<HOLD_MAX: lock owner=gnt, hold_cnt++.
//   - Otherwise: lock cleared, hold_cnt=0.
//   - In IDLE, if the owner is not requesting, the lock clears and normal rotation applies.
//   - hold_cnt==HOLD_MAX forces clear. At most HOLD_MAX+1 consecutive grants to one master.
//   - hold_cnt is $clog2(HOLD_MAX+1) bits wide.
//  ISSUE:
//   - Well-formed (exactly one of rd/wr set): drive mmio_cs=1 with the matching strobe for exactly one cycle.
//   - Same edge: m_rd_data <= rd ? mmio_rd_data : 32'h0.
//   - Malformed (rd&wr, or neither): no bus strobes; m_rd_data <= 0; flag err.
//  ACK: m_ack[gnt]=1 for one cycle; m_err[gnt]=err. The other master's ack/err stay 0.
//  Bus signals:
//   - mmio_cs, mmio_rd and mmio_wr are 0 outside ISSUE.
//   - mmio_addr and mmio_wr_data hold their last values.
//   - m_rd_data holds until the next ISSUE.
//  Master rule: drop m_req (or present a new transaction) in the cycle after seeing m_ack.
//   The arbiter never samples m_req during ISSUE or ACK.
//   Request-input changes during ISSUE or ACK have no effect.
//  Reset mid-transaction: the bus cycle is aborted and no ack is issued; the master must re-request.
// TESTING
//  1. Single read: m0 req rd addr=0x000C0, mmio_rd_data=0xA5A5_0001.
//     -> mmio_cs/rd high in cycle N+1 only; m_ack[0] in N+2; m_rd_data=0xA5A5_0001.
//  2. Both masters request continuously, no lock.
//     -> grants alternate 0,1,0,1 (m0 first after reset); one bus cycle per 3 clocks.
//  3. Lock bound: m1 holds m_lock=1 and requests continuously; m0 also requests; HOLD_MAX=4.
//     -> m1 gets 5 consecutive grants, then m0 gets the next grant.
//  4. Malformed: m0 req with rd=wr=1.
//     -> no mmio_cs; m_ack[0]=m_err[0]=1 in N+2; m_rd_data=0.
//  5. Write: m1 writes 0x1234_5678 to addr 0x00280.
//     -> mmio_wr/cs for one cycle with that addr/data; m_rd_data=0; m_ack[1] pulses.
//  6. Reset asserted during ISSUE.
//     -> mmio_cs drops immediately; no m_ack; after release, m0 wins a tie first.

Source files
------------

// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the FPro MMIO bus with a bounded lock
// that lets one master keep the bus for back-to-back transactions.
module mmio_bus_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_wr,
  input  logic [1:0]  m_rd,
  input  logic [1:0]  m_lock,
  input  logic [41:0] m_addr,
  input  logic [63:0] m_wr_data,
  output logic [1:0]  m_ack,
  output logic [1:0]  m_err,
  output logic [31:0] m_rd_data,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_MAX_C = CW'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t          state_reg, state_next;
  logic            last_gnt_reg, gnt_reg;
  logic            lock_on_reg, lock_own_reg;
  logic [CW-1:0]   hold_cnt_reg;
  logic [20:0]     addr_reg;
  logic [31:0]     wr_data_reg, rd_data_reg;
  logic            rd_reg, wr_reg;

  logic            lock_hit, grant_valid, gnt_sel, well_formed;
  logic [CW-1:0]   hold_eff;
  logic [20:0]     addr_slice [2];
  logic [31:0]     data_slice [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      assign addr_slice[gi] = m_addr[21*gi +: 21];
      assign data_slice[gi] = m_wr_data[32*gi +: 32];
    end
  endgenerate

  // A lock only counts while its owner keeps requesting; otherwise rotation resumes.
  always_comb begin
    lock_hit    = lock_on_reg && m_req[lock_own_reg];
    grant_valid = |m_req;
    if (lock_hit)
      gnt_sel = lock_own_reg;
    else if (m_req == 2'b10)
      gnt_sel = 1'b1;
    else if (m_req == 2'b01)
      gnt_sel = 1'b0;
    else
      gnt_sel = ~last_gnt_reg;
    hold_eff = lock_hit ? hold_cnt_reg : '0;
  end

  assign well_formed = rd_reg ^ wr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_reg <= 1'b1;
      gnt_reg      <= 1'b0;
      lock_on_reg  <= 1'b0;
      lock_own_reg <= 1'b0;
      hold_cnt_reg <= '0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            gnt_reg      <= gnt_sel;
            last_gnt_reg <= gnt_sel;
            addr_reg     <= addr_slice[gnt_sel];
            wr_data_reg  <= data_slice[gnt_sel];
            rd_reg       <= m_rd[gnt_sel];
            wr_reg       <= m_wr[gnt_sel];
            if (m_lock[gnt_sel] && (hold_eff < HOLD_MAX_C)) begin
              lock_on_reg  <= 1'b1;
              lock_own_reg <= gnt_sel;
              hold_cnt_reg <= hold_eff + CW'(1);
            end else begin
              lock_on_reg  <= 1'b0;
              hold_cnt_reg <= '0;
            end
          end else if (!lock_hit) begin
            lock_on_reg  <= 1'b0;
            hold_cnt_reg <= '0;
          end
        end
        ISSUE: rd_data_reg <= (rd_reg && !wr_reg) ? mmio_rd_data : 32'h0;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_ack        = 2'b00;
    m_err        = 2'b00;
    mmio_cs      = 1'b0;
    mmio_rd      = 1'b0;
    mmio_wr      = 1'b0;
    mmio_addr    = addr_reg;
    mmio_wr_data = wr_data_reg;
    m_rd_data    = rd_data_reg;
    if (state_reg == ISSUE && well_formed) begin
      mmio_cs = 1'b1;
      mmio_rd = rd_reg;
      mmio_wr = wr_reg;
    end
    if (state_reg == ACK) begin
      m_ack[gnt_reg] = 1'b1;
      m_err[gnt_reg] = ~well_formed;
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Randomized bench for mmio_bus_arbiter: a transaction-level model predicts
// every bus cycle and ack, plus directed grant-order and reset scenarios.
module tb_mmio_bus_arbiter;
  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req, m_wr, m_rd, m_lock;
  logic [41:0] m_addr;
  logic [63:0] m_wr_data;
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rd_data;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  mmio_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_rd(m_rd),
    .m_lock(m_lock), .m_addr(m_addr), .m_wr_data(m_wr_data), .m_ack(m_ack),
    .m_err(m_err), .m_rd_data(m_rd_data), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr),
    .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: busy counts cycles since the grant (0 = free).
  int          busy, cur, last, lock_own, streak;
  bit          lock_on;
  logic [20:0] t_addr, e_addr;
  logic [31:0] t_data, e_wdata, e_rdata;
  logic        t_rd, t_wr;

  // Stimulus knobs
  int  req_pct, raise_pct;
  int  lock_pct [2];
  bit  fixed_rd;
  int  gq [$];

  task automatic model_reset();
    busy = 0; cur = 0; last = 1; lock_on = 0; lock_own = 0; streak = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; t_rd = 0; t_wr = 0;
  endtask

  task automatic model_edge();
    int w;
    w = -1;
    if (busy == 0) begin
      if (lock_on && m_req[lock_own]) w = lock_own;
      else begin
        lock_on = 0; streak = 0;
        if (m_req == 2'b11) w = 1 - last;
        else if (m_req[0]) w = 0;
        else if (m_req[1]) w = 1;
      end
      if (w >= 0) begin
        if (m_lock[w] && streak < HOLD_MAX) begin
          lock_on = 1; lock_own = w; streak++;
        end else begin
          lock_on = 0; streak = 0;
        end
        cur = w; last = w;
        t_addr = m_addr[21*w +: 21];
        t_data = m_wr_data[32*w +: 32];
        t_rd = m_rd[w]; t_wr = m_wr[w];
        e_addr = t_addr; e_wdata = t_data;
        busy = 1;
      end
    end else if (busy == 1) begin
      e_rdata = (t_rd && !t_wr) ? mmio_rd_data : 32'h0;
      busy = 2;
    end else begin
      busy = 0;
    end
  endtask

  task automatic compare();
    logic [1:0] ea, ee;
    logic       ecs;
    ea  = (busy == 2) ? ((cur == 1) ? 2'b10 : 2'b01) : 2'b00;
    ee  = (t_rd ^ t_wr) ? 2'b00 : ea;
    ecs = (busy == 1) && (t_rd ^ t_wr);
    check("m_ack", 64'(m_ack), 64'(ea));
    check("m_err", 64'(m_err), 64'(ee));
    check("mmio_cs", 64'(mmio_cs), 64'(ecs));
    check("mmio_rd", 64'(mmio_rd), 64'(ecs & t_rd));
    check("mmio_wr", 64'(mmio_wr), 64'(ecs & t_wr));
    check("mmio_addr", 64'(mmio_addr), 64'(e_addr));
    check("mmio_wr_data", 64'(mmio_wr_data), 64'(e_wdata));
    check("m_rd_data", 64'(m_rd_data), 64'(e_rdata));
  endtask

  task automatic new_txn(input int i);
    int r;
    r = $urandom_range(0, 7);
    m_req[i] = 1'b1;
    m_rd[i]  = (r < 4) || (r == 7 && $urandom_range(0, 1) == 1);
    m_wr[i]  = (r >= 4 && r < 7) || (r == 7 && m_rd[i]);
    m_addr[21*i +: 21]    = 21'($urandom);
    m_wr_data[32*i +: 32] = $urandom;
    m_lock[i] = ($urandom_range(0, 99) < lock_pct[i]);
  endtask

  task automatic masters_update();
    for (int i = 0; i < 2; i++) begin
      if (busy == 2 && cur == i) begin
        if ($urandom_range(0, 99) < req_pct) new_txn(i);
        else begin
          m_req[i] = 1'b0;
          m_rd[i]  = 1'($urandom);
          m_wr[i]  = 1'($urandom);
        end
      end else if (busy == 1 && cur == i) begin
        m_addr[21*i +: 21]    = 21'($urandom);
        m_wr_data[32*i +: 32] = $urandom;
        m_rd[i]   = 1'($urandom);
        m_wr[i]   = 1'($urandom);
        m_lock[i] = 1'($urandom);
      end else if (!m_req[i] && $urandom_range(0, 99) < raise_pct) begin
        new_txn(i);
      end
    end
  endtask

  task automatic step();
    mmio_rd_data = fixed_rd ? 32'hA5A5_0001 : $urandom;
    model_edge();
    @(posedge clk);
    #1;
    compare();
    if (m_ack != 2'b00) gq.push_back(m_ack[1] ? 1 : 0);
    masters_update();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    int exp_g;
    reset = 1'b1;
    m_req = '0; m_wr = '0; m_rd = '0; m_lock = '0;
    m_addr = '0; m_wr_data = '0; mmio_rd_data = 32'hFFFF_FFFF;
    req_pct = 0; raise_pct = 0; lock_pct[0] = 0; lock_pct[1] = 0; fixed_rd = 0;
    model_reset();
    #2;
    check("reset_outputs", {m_ack, m_err, mmio_cs, mmio_rd, mmio_wr, 2'b00}, 64'h0);
    check("reset_addr", 64'(mmio_addr), 64'h0);
    check("reset_wr_data", 64'(mmio_wr_data), 64'h0);
    check("reset_rd_data", 64'(m_rd_data), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read by master 0
    fixed_rd = 1;
    m_req[0] = 1'b1; m_rd[0] = 1'b1; m_wr[0] = 1'b0; m_lock[0] = 1'b0;
    m_addr[20:0] = 21'h000C0;
    for (int k = 0; k < 5; k++) step();
    check("single_read_data", 64'(m_rd_data), 64'hA5A5_0001);
    fixed_rd = 0;

    // Both request continuously without lock: strict alternation from m0
    do_reset();
    req_pct = 100; raise_pct = 100;
    new_txn(0); new_txn(1);
    gq.delete();
    for (int k = 0; k < 30; k++) step();
    check("alt_count", 64'(gq.size() >= 8), 64'h1);
    for (int j = 0; j < 8 && j < gq.size(); j++)
      check($sformatf("alt_grant%0d", j), 64'(gq[j]), 64'(j % 2));

    // m1 locking continuously: five m1 grants then one m0 grant, repeating
    do_reset();
    lock_pct[1] = 100;
    new_txn(0); new_txn(1);
    gq.delete();
    for (int k = 0; k < 45; k++) step();
    check("lock_count", 64'(gq.size() >= 13), 64'h1);
    for (int j = 0; j < 13 && j < gq.size(); j++) begin
      exp_g = (j == 0) ? 0 : (((j - 1) % 6 < HOLD_MAX + 1) ? 1 : 0);
      check($sformatf("lock_grant%0d", j), 64'(gq[j]), 64'(exp_g));
    end

    // Random traffic against the model
    do_reset();
    req_pct = 60; raise_pct = 30; lock_pct[0] = 40; lock_pct[1] = 40;
    m_req = '0;
    for (int k = 0; k < 3000; k++) step();

    // Reset asserted while a bus cycle is in flight
    req_pct = 100; raise_pct = 100;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      if (busy == 1 && (t_rd ^ t_wr)) found = 1;
    end
    check("issue_reached", 64'(found), 64'h1);
    reset = 1'b1;
    #1;
    check("abort_cs", {mmio_cs, mmio_rd, mmio_wr}, 64'h0);
    check("abort_ack", 64'(m_ack), 64'h0);
    model_reset();
    @(posedge clk); #1;
    check("abort_no_ack", 64'(m_ack), 64'h0);
    lock_pct[0] = 0; lock_pct[1] = 0;
    new_txn(0); new_txn(1);
    reset = 1'b0;
    gq.delete();
    for (int k = 0; k < 6; k++) step();
    check("post_reset_count", 64'(gq.size() >= 1), 64'h1);
    if (gq.size() >= 1) check("post_reset_first", 64'(gq[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
